// File: rtl/uart_rx_buffer_pkg.sv
// uart_rx_buffer_pkg: shared depth default and hub status-byte bit positions
package uart_rx_buffer_pkg;
  localparam int UART_RX_BUFFER_DEPTH_LOG2_DEFAULT = 4;
  localparam int UART_STAT_RX_FULL_BIT = 5;
  localparam int UART_STAT_RX_HALF_FULL_BIT = 4;
  localparam int UART_STAT_RX_DATA_PRESENT_BIT = 3;
  localparam int UART_STAT_TX_FULL_BIT = 2;
  localparam int UART_STAT_TX_HALF_FULL_BIT = 1;
  localparam int UART_STAT_TX_DATA_PRESENT_BIT = 0;
endpackage

// File: rtl/uart_rx_buffer_fifo_mem_dp.sv
// fifo_mem_dp: 2^N x 8 storage, synchronous write port, asynchronous read port
module fifo_mem_dp #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [N-1:0] waddr,
  input  logic [7:0]   wdata,
  input  logic [N-1:0] raddr,
  output logic [7:0]   rdata
);
  logic [7:0] mem [2**N];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: FWFT byte FIFO from UART receiver to hub; sticky overflow flag built only with UART_RX_BUFFER_OVERFLOW_FLAG_EN
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_RX_BUFFER_DEPTH_LOG2_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       write,
  output logic [7:0] data_out,
  input  logic       read,
  output logic       full,
  output logic       half_full,
  output logic       data_present,
  output logic       overflow,
  input  logic       overflow_clear
);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] HALF_CNT = {2'b01, {(DEPTH_LOG2-1){1'b0}}};
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0] count;
  logic wr_ok, rd_ok;
  assign full = count == FULL_CNT;
  assign half_full = count >= HALF_CNT;
  assign data_present = |count;
  assign rd_ok = read & data_present;
  assign wr_ok = write & (~full | read);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wp <= wp + DEPTH_LOG2'(1);
      if (rd_ok) rp <= rp + DEPTH_LOG2'(1);
      count <= count + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(rd_ok);
    end
  fifo_mem_dp #(.N(DEPTH_LOG2)) u_mem (
    .clk(clk),
    .we(wr_ok),
    .waddr(wp),
    .wdata(din),
    .raddr(rp),
    .rdata(data_out)
  );
`ifdef UART_RX_BUFFER_OVERFLOW_FLAG_EN
  logic ovf;
  always_ff @(posedge clk or posedge reset)
    if (reset) ovf <= 1'b0;
    else if (write & ~wr_ok) ovf <= 1'b1;
    else if (overflow_clear) ovf <= 1'b0;
  assign overflow = ovf;
`else
  logic unused_clear;
  assign unused_clear = overflow_clear;
  assign overflow = 1'b0;
`endif
endmodule
